// File: rtl/rsp_fifo_ctl.sv
// First-word-fall-through response FIFO toward the RV core, with registered
// occupancy flags and sticky write-side protocol error reporting.
module rsp_fifo_ctl #(
  parameter  int DATA_WIDTH = 64,
  parameter  int DEPTH      = 8,
  parameter  int AFULL_TH   = 6,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsp_fifo_wr_en,
  input  logic [DATA_WIDTH-1:0] rsp_fifo_wr_data,
  output logic                  rsp_fifo_full,
  output logic                  rsp_fifo_afull,
  output logic [PTR_W:0]        rsp_fifo_cnt,
  output logic                  rv_rsp_vld,
  output logic [DATA_WIDTH-1:0] rv_rsp_data,
  input  logic                  rv_rsp_rdy,
  output logic                  ovf_err,
  output logic                  udf_err,
  input  logic                  err_clr
);

  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_AFULL = (PTR_W+1)'(AFULL_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] cnt_q, cnt_d;
  logic           full_q, full_d;
  logic           afull_q, afull_d;
  logic           ovf_q, ovf_d;
  logic           udf_q, udf_d;

  logic push, pop, ptr_empty;

  // Push is gated by the registered full flag, so a push offered in the
  // cycle a full FIFO pops is still refused.
  assign push      = rsp_fifo_wr_en & ~full_q;
  assign pop       = rv_rsp_vld & rv_rsp_rdy;
  assign ptr_empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CNT_FULL);
    afull_d = (cnt_d >= CNT_AFULL);
    // Set has priority over a coincident clear.
    ovf_d   = (ovf_q & ~err_clr) | (rsp_fifo_wr_en & full_q);
    udf_d   = (udf_q & ~err_clr) | (pop & ptr_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage carries no reset; stale words are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q[PTR_W-1:0]] <= rsp_fifo_wr_data;
  end

  assign rv_rsp_vld     = (cnt_q != '0);
  assign rv_rsp_data    = rv_rsp_vld ? mem_q[rd_ptr_q[PTR_W-1:0]] : '0;
  assign rsp_fifo_cnt   = cnt_q;
  assign rsp_fifo_full  = full_q;
  assign rsp_fifo_afull = afull_q;
  assign ovf_err        = ovf_q;
  assign udf_err        = udf_q;

endmodule

// File: tb/tb_rsp_fifo_ctl.sv
// Randomized and directed bench for rsp_fifo_ctl against a queue-based model.
module tb_rsp_fifo_ctl;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int AFTH  = 3;

  logic          clk = 1'b0;
  logic          rst, wr_en, rdy, err_clr;
  logic [DW-1:0] wr_data;
  logic          full, afull, vld, ovf, udf;
  logic [2:0]    cnt;
  logic [DW-1:0] rdata;

  rsp_fifo_ctl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_TH(AFTH)) dut (
    .clk(clk), .rst(rst),
    .rsp_fifo_wr_en(wr_en), .rsp_fifo_wr_data(wr_data),
    .rsp_fifo_full(full), .rsp_fifo_afull(afull), .rsp_fifo_cnt(cnt),
    .rv_rsp_vld(vld), .rv_rsp_data(rdata), .rv_rsp_rdy(rdy),
    .ovf_err(ovf), .udf_err(udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mq[$];
  bit            m_ovf;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit we, input logic [DW-1:0] d,
                     input bit rd, input bit clr);
    bit m_full, m_push, m_pop;
    rst = r; wr_en = we; wr_data = d; rdy = rd; err_clr = clr;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_pop  = rd && (mq.size() != 0);
      m_push = we && !m_full;
      if (m_pop)  void'(mq.pop_front());
      if (m_push) mq.push_back(d);
      m_ovf = (we && m_full) || (m_ovf && !clr);
    end
    #1;
    chk("cnt",   64'(cnt),   64'(mq.size()));
    chk("full",  64'(full),  64'(mq.size() == DEPTH));
    chk("afull", 64'(afull), 64'(mq.size() >= AFTH));
    chk("vld",   64'(vld),   64'(mq.size() != 0));
    chk("data",  rdata,      (mq.size() != 0) ? mq[0] : 64'h0);
    chk("ovf",   64'(ovf),   64'(m_ovf));
    chk("udf",   64'(udf),   64'h0);
  endtask

  initial begin
    int pushed;
    bit we, rd;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rdy = 1'b1; err_clr = 1'b0;

    // Reset with rdy held high
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Fill with rdy low, then drain in order
    for (int i = 0; i < 4; i++) cyc(0, 1, 64'hA0 + 64'(i), 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);

    // Overflow: dropped word, sticky flag, clear, set-wins-over-clear
    for (int i = 0; i < 4; i++) cyc(0, 1, 64'hB0 + 64'(i), 0, 0);
    cyc(0, 1, 64'hFF, 0, 0);
    cyc(0, 1, 64'hFF, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 64'hFF, 0, 1);
    cyc(0, 0, 0, 0, 1);

    // Full + pop with a push offered: push is still blocked
    cyc(0, 1, 64'hEE, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Simultaneous push/pop at cnt=2 across several pointer wraps
    for (int i = 0; i < 20; i++) cyc(0, 1, 64'h100 + 64'(i), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);

    // Random back-pressure, 100 accepted pushes, bounded
    pushed = 0;
    for (int n = 0; n < 3000 && pushed < 100; n++) begin
      we = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (we && mq.size() != DEPTH) pushed++;
      cyc(0, we, {$urandom, $urandom}, rd, 0);
    end
    chk("rand_budget", 64'(pushed), 64'd100);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);

    // Reset mid-stream at cnt=3 during a push and a pop
    for (int i = 0; i < 3; i++) cyc(0, 1, 64'hC0 + 64'(i), 0, 0);
    cyc(1, 1, 64'h77, 1, 0);
    chk("mid_rst_cnt", 64'(cnt), 64'd0);
    chk("mid_rst_vld", 64'(vld), 64'd0);
    cyc(0, 1, 64'h55, 0, 0);
    chk("head_55", rdata, 64'h55);
    chk("cnt_55", 64'(cnt), 64'd1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
